// File: rtl/mux161_rr_sched.sv
// Round-robin scheduler for a 16:1 mux. It grants one requester at a time and
// holds each grant for at most BURST cycles. All outputs are registered.
module mux161_rr_sched #(
  parameter int unsigned BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic [7:0]  grant_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] gnt_q, gnt_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic [7:0]  grant_count_q, grant_count_d;

  // Rotate the request vector so ptr lands at bit 0. The lowest set bit of the
  // rotated vector is then the offset of the winner from ptr.
  logic [31:0] req_dbl;
  logic [15:0] req_rot;
  logic [3:0]  win_off;
  logic [3:0]  winner;
  logic        any_req;
  logic        release_now;

  assign req_dbl = {req, req} >> ptr_q;
  assign req_rot = req_dbl[15:0];
  assign any_req = |req;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    win_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) win_off = 4'(i);
    end
  end

  assign winner      = ptr_q + win_off;
  assign release_now = !req[sel_q] || (cnt_q == CNT_LAST) || !en;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    gnt_d         = gnt_q;
    gnt_valid_d   = gnt_valid_q;
    grant_count_d = grant_count_q;

    unique case (state_q)
      IDLE: begin
        gnt_d       = 16'h0000;
        gnt_valid_d = 1'b0;
        if (en && any_req) begin
          state_d       = GRANT;
          sel_d         = winner;
          gnt_d         = 16'h0001 << winner;
          gnt_valid_d   = 1'b1;
          cnt_d         = 8'd0;
          grant_count_d = grant_count_q + 8'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Releasing always costs one idle cycle, even when the same
          // requester would win again.
          state_d     = IDLE;
          gnt_d       = 16'h0000;
          gnt_valid_d = 1'b0;
          ptr_d       = sel_q + 4'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: async active-low reset clears every flop, including the grant, so a
  // reset mid-grant drops it at once without the release bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 4'd0;
      cnt_q         <= 8'd0;
      sel_q         <= 4'd0;
      gnt_q         <= 16'h0000;
      gnt_valid_q   <= 1'b0;
      grant_count_q <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from values sampled before the edge.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      gnt_q         <= gnt_d;
      gnt_valid_q   <= gnt_valid_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign gnt_valid   = gnt_valid_q;
  assign grant_count = grant_count_q;

endmodule
